// File: rtl/encoder_scan_if.sv
// Handshake bundle for encoder_scan: vector-in channel and beat-out channel.
// master = producer/consumer side, slave = the encoder.
interface encoder_scan_if #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_vec;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             out_err;

  modport master (
    output in_valid, in_vec, out_ready,
    input  in_ready, out_valid, out_idx, out_last, out_err
  );

  modport slave (
    input  in_valid, in_vec, out_ready,
    output in_ready, out_valid, out_idx, out_last, out_err
  );
endinterface

// File: rtl/encoder_scan.sv
// Bit-index encoder: MODE 0 enumerates set bits LSB first, MODE 1 strict one-hot.
// Optional saturating error-beat counter when ENC_ERR_CNT_EN is defined.
module encoder_scan #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH),
  parameter int MODE  = 0
) (
  input  logic          clk,
  input  logic          rst,
  encoder_scan_if.slave bus
`ifdef ENC_ERR_CNT_EN
  ,
  output logic [15:0]   err_cnt
`endif
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] pend_q, pend_d;

  logic [WIDTH-1:0] low_bit;
  logic [WIDTH-1:0] rest;
  logic             is_zero;
  logic             one_hot;
  logic [IDX_W-1:0] beat_idx;
  logic             beat_last;
  logic             beat_err;
  logic             beat_hs;

  function automatic logic [IDX_W-1:0] low_idx(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  // Beat derivation: the current beat is always a function of what remains pending.
  always_comb begin
    low_bit = pend_q & (~pend_q + WIDTH'(1));
    rest    = pend_q & ~low_bit;
    is_zero = (pend_q == '0);
    one_hot = !is_zero && (rest == '0);
    if (MODE == 1) begin
      beat_idx  = one_hot ? low_idx(pend_q) : '0;
      beat_err  = !one_hot;
      beat_last = 1'b1;
    end else begin
      beat_idx  = low_idx(pend_q);
      beat_err  = is_zero;
      beat_last = (rest == '0);
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == SCAN);
  assign bus.out_idx   = bus.out_valid ? beat_idx  : '0;
  assign bus.out_last  = bus.out_valid ? beat_last : 1'b0;
  assign bus.out_err   = bus.out_valid ? beat_err  : 1'b0;
  assign beat_hs       = bus.out_valid && bus.out_ready;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          pend_d  = bus.in_vec;
          state_d = SCAN;
        end
      end
      default: begin
        if (beat_hs) begin
          if (beat_last) begin
            pend_d  = '0;
            state_d = IDLE;
          end else begin
            pend_d  = rest;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

`ifdef ENC_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (beat_hs && beat_err && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_encoder_scan.sv
// Directed bench for encoder_scan: MODE 0 and MODE 1 instances, scoreboard of beats.
module tb_encoder_scan;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  encoder_scan_if #(.WIDTH(8)) b0();
  encoder_scan_if #(.WIDTH(8)) b1();

`ifdef ENC_ERR_CNT_EN
  logic [15:0] ec0, ec1;
`endif

  encoder_scan #(.WIDTH(8), .MODE(0)) u0 (
    .clk(clk), .rst(rst), .bus(b0)
`ifdef ENC_ERR_CNT_EN
    , .err_cnt(ec0)
`endif
  );

  encoder_scan #(.WIDTH(8), .MODE(1)) u1 (
    .clk(clk), .rst(rst), .bus(b1)
`ifdef ENC_ERR_CNT_EN
    , .err_cnt(ec1)
`endif
  );

  typedef logic [4:0] beat_t; // {idx[2:0], last, err}
  beat_t q0[$];
  beat_t q1[$];
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic beat_t mk(input int idx, input bit last, input bit err);
    return {idx[2:0], last, err};
  endfunction

  always @(negedge clk) begin
    if (!rst && b0.out_valid && b0.out_ready) begin
      if (q0.size() == 0) chk("m0_extra_beat", 32'(q0.size()), 32'd1);
      else chk("m0_beat", {27'd0, b0.out_idx, b0.out_last, b0.out_err}, {27'd0, q0.pop_front()});
    end
    if (!rst && b1.out_valid && b1.out_ready) begin
      if (q1.size() == 0) chk("m1_extra_beat", 32'(q1.size()), 32'd1);
      else chk("m1_beat", {27'd0, b1.out_idx, b1.out_last, b1.out_err}, {27'd0, q1.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    b0.in_valid = 0; b0.in_vec = '0; b0.out_ready = 1;
    b1.in_valid = 0; b1.in_vec = '0; b1.out_ready = 1;
    rst = 1;
    step(); step();
    rst = 0;
    chk("rst_in_ready0", b0.in_ready, 1);
    chk("rst_out_valid0", b0.out_valid, 0);
    chk("rst_outs0", {b0.out_idx, b0.out_last, b0.out_err}, 0);
    chk("rst_in_ready1", b1.in_ready, 1);
`ifdef ENC_ERR_CNT_EN
    chk("rst_err_cnt0", ec0, 0);
`endif

    // single bit, one beat
    b0.in_vec = 8'h01; b0.in_valid = 1; q0.push_back(mk(0, 1, 0));
    step(); b0.in_valid = 0;
    chk("h01_valid", b0.out_valid, 1);
    chk("h01_ready", b0.in_ready, 0);
    chk("h01_beat", {b0.out_idx, b0.out_last, b0.out_err}, mk(0, 1, 0));
    step();
    chk("h01_idle", {b0.in_ready, b0.out_valid}, 2'b10);

    // multi-bit full throughput
    b0.in_vec = 8'h94; b0.in_valid = 1;
    q0.push_back(mk(2, 0, 0)); q0.push_back(mk(4, 0, 0)); q0.push_back(mk(7, 1, 0));
    step(); b0.in_valid = 0;
    chk("h94_b0", {b0.in_ready, b0.out_valid, b0.out_idx, b0.out_last}, {2'b01, 3'd2, 1'b0});
    step();
    chk("h94_b1", {b0.in_ready, b0.out_valid, b0.out_idx, b0.out_last}, {2'b01, 3'd4, 1'b0});
    step();
    chk("h94_b2", {b0.in_ready, b0.out_valid, b0.out_idx, b0.out_last}, {2'b01, 3'd7, 1'b1});
    step();
    chk("h94_idle", {b0.in_ready, b0.out_valid, b0.out_idx, b0.out_last}, {2'b10, 3'd0, 1'b0});

    // backpressure; inputs during SCAN must be ignored
    b0.out_ready = 0; b0.in_vec = 8'h03; b0.in_valid = 1;
    q0.push_back(mk(0, 0, 0)); q0.push_back(mk(1, 1, 0));
    step(); b0.in_vec = 8'hF0;
    for (int k = 0; k < 3; k++) begin
      chk("h03_stall", {b0.out_valid, b0.out_idx, b0.out_last, b0.out_err}, {1'b1, 3'd0, 2'b00});
      step();
    end
    b0.in_valid = 0; b0.out_ready = 1;
    step();
    chk("h03_b1", {b0.out_valid, b0.out_idx, b0.out_last}, {1'b1, 3'd1, 1'b1});
    step();
    chk("h03_idle", {b0.in_ready, b0.out_valid}, 2'b10);

    // zero vector
    b0.in_vec = 8'h00; b0.in_valid = 1; q0.push_back(mk(0, 1, 1));
    step(); b0.in_valid = 0;
    chk("h00_beat", {b0.out_valid, b0.out_idx, b0.out_last, b0.out_err}, {1'b1, 3'd0, 2'b11});
    step();
    chk("h00_idle", {b0.in_ready, b0.out_valid, b0.out_err}, 3'b100);
`ifdef ENC_ERR_CNT_EN
    chk("h00_err_cnt", ec0, 1);
`endif

    // strict one-hot
    b1.in_vec = 8'h06; b1.in_valid = 1; q1.push_back(mk(0, 1, 1));
    step(); b1.in_valid = 0;
    chk("m1_h06", {b1.out_valid, b1.out_idx, b1.out_last, b1.out_err}, {1'b1, 3'd0, 2'b11});
    step();
    b1.in_vec = 8'h80; b1.in_valid = 1; q1.push_back(mk(7, 1, 0));
    step(); b1.in_valid = 0;
    chk("m1_h80", {b1.out_valid, b1.out_idx, b1.out_last, b1.out_err}, {1'b1, 3'd7, 2'b10});
    step();
    b1.in_vec = 8'h00; b1.in_valid = 1; q1.push_back(mk(0, 1, 1));
    step(); b1.in_valid = 0;
    chk("m1_h00", {b1.out_valid, b1.out_idx, b1.out_last, b1.out_err}, {1'b1, 3'd0, 2'b11});
    step();
    chk("m1_idle", {b1.in_ready, b1.out_valid}, 2'b10);
`ifdef ENC_ERR_CNT_EN
    chk("m1_err_cnt", ec1, 2);
`endif

    // reset mid-scan discards remaining beats
    b0.in_vec = 8'hFF; b0.in_valid = 1;
    q0.push_back(mk(0, 0, 0)); q0.push_back(mk(1, 0, 0)); q0.push_back(mk(2, 0, 0));
    step(); b0.in_valid = 0;
    step(); step(); step();
    chk("hFF_mid", {b0.out_valid, b0.out_idx}, {1'b1, 3'd3});
    rst = 1;
    step(); rst = 0;
    chk("rst_mid_state", {b0.in_ready, b0.out_valid, b0.out_idx, b0.out_last, b0.out_err}, {2'b10, 3'd0, 2'b00});
    chk("rst_mid_q", 32'(q0.size()), 0);
`ifdef ENC_ERR_CNT_EN
    chk("rst_mid_err_cnt", ec0, 0);
`endif
    b0.in_vec = 8'h10; b0.in_valid = 1; q0.push_back(mk(4, 1, 0));
    step(); b0.in_valid = 0;
    chk("h10_beat", {b0.out_valid, b0.out_idx, b0.out_last, b0.out_err}, {1'b1, 3'd4, 2'b10});
    step();
    chk("h10_idle", {b0.in_ready, b0.out_valid}, 2'b10);

    for (int k = 0; k < 20 && (q0.size() != 0 || q1.size() != 0); k++) step();
    chk("drain_q0", 32'(q0.size()), 0);
    chk("drain_q1", 32'(q1.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/encoder_scan.md
ENCODER_SCAN -- requirements
Module: encoder_scan

Interface
REQ-001 SHALL provide parameter: WIDTH, 8, input vector width (>=2).
REQ-002 SHALL provide parameter: IDX_W, $clog2(WIDTH) (3 at default), output index width.
REQ-003 SHALL provide parameter: MODE, 0, 0 = enumerate every set bit; 1 = strict one-hot encode.
REQ-004 SHALL provide port: clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL provide port: rst  input  1  synchronous, active-high reset.
REQ-006 SHALL provide port: in_valid  input  1  in_vec valid.
REQ-007 SHALL provide port: in_ready  output  1  block can accept a vector.
REQ-008 SHALL provide port: in_vec  input  WIDTH  vector to encode.
REQ-009 SHALL provide port: out_valid  output  1  output beat valid.
REQ-010 SHALL provide port: out_ready  input  1  consumer accepts beat.
REQ-011 SHALL provide port: out_idx  output  IDX_W  encoded bit index.
REQ-012 SHALL provide port: out_last  output  1  final beat for the accepted vector.
REQ-013 SHALL provide port: out_err  output  1  vector zero (any MODE) or not one-hot (MODE 1).

Function
REQ-014 SHALL implement a two-state FSM: IDLE (in_ready=1, out_valid=0) and SCAN (in_ready=0, out_valid=1).
REQ-015 SHALL accept a vector on the cycle in_valid && in_ready, latch it into a pending register, and enter SCAN; out_valid SHALL rise exactly one cycle after acceptance.
REQ-016 SHALL, for in_vec == 0 in either MODE, emit one beat: out_idx=0, out_err=1, out_last=1.
REQ-017 SHALL, in MODE 0, emit one beat per set bit in ascending index order (LSB first), out_err=0, out_last=1 only on the highest set bit.
REQ-018 SHALL, in MODE 1, emit exactly one beat: the set bit index with out_err=0 if in_vec is one-hot, else out_idx=0, out_err=1; out_last=1 always.
REQ-019 SHALL hold out_idx, out_last, out_err stable while out_valid && !out_ready.
REQ-020 SHALL, on out_valid && out_ready, clear the emitted bit from the pending register and present the next beat the following cycle (one beat per cycle at full throughput).
REQ-021 SHALL, on handshake of the out_last beat, return to IDLE; in_ready SHALL be 1 the next cycle (no acceptance on the last-beat cycle).
REQ-022 SHALL ignore in_vec and in_valid while in SCAN.
REQ-023 SHALL drive out_idx, out_last, out_err to 0 whenever out_valid=0.

Reset
REQ-024 SHALL, with rst high at a clock edge, enter IDLE, clear the pending register, and drive out_valid=0, out_idx=0, out_last=0, out_err=0, in_ready=1 from the next cycle.
REQ-025 SHALL let rst take priority over any simultaneous handshake, discarding pending beats mid-scan.

Configuration
REQ-026 SHALL, with macro ENC_ERR_CNT_EN defined, add output err_cnt (16 bits, reset 0) counting handshaken beats with out_err=1, saturating at 16'hFFFF.
REQ-027 SHALL, without ENC_ERR_CNT_EN, omit the err_cnt port and counter; all other behaviour identical.

Verification
REQ-028 SHALL cover: MODE 0, in_vec=8'h01 -> one beat idx=0, last=1, err=0, out_valid one cycle after accept.
REQ-029 SHALL cover: MODE 0, in_vec=8'h94, out_ready=1 -> beats idx 2,4,7 on consecutive cycles, last only on 7, in_ready=0 throughout, 1 the cycle after.
REQ-030 SHALL cover: MODE 0, in_vec=8'h03, out_ready low 3 cycles -> idx=0 held stable, then beats 0,1, none lost or duplicated.
REQ-031 SHALL cover: in_vec=8'h00 -> one beat idx=0, err=1, last=1; with ENC_ERR_CNT_EN, err_cnt=1 afterward.
REQ-032 SHALL cover: MODE 1, in_vec=8'h06 -> err=1, last=1; then 8'h80 -> idx=7, err=0.
REQ-033 SHALL cover: MODE 0, in_vec=8'hFF, rst after 3 beats -> next cycle out_valid=0, in_ready=1, err_cnt=0, fresh 8'h10 yields idx=4 only.
